// File: rtl/switch_pkg.sv
// Shared definitions for the serial packet switch and its ingress logic.
// Register addresses are for system-level benches that program the switch.
package switch_pkg;

  localparam int PKT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_ID      = 8'h04;
  localparam logic [7:0] REG_PORT_EN = 8'h08;

endpackage

// File: rtl/switch_ingress_arb_if.sv
// Requester-side bus plus serial output pins of the ingress arbiter.
// The slave modport is the arbiter; the master modport is the surrounding logic.
interface switch_ingress_arb_if
  import switch_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic                     en;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PKT_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     data_out;
  logic                     valid_out;
  logic                     busy;
  logic [IDW-1:0]           grant_id;
  logic [15:0]              pkt_count;

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, data_out, valid_out, busy, grant_id, pkt_count
  );

  modport master (
    output en, req_valid, req_data,
    input  req_ready, data_out, valid_out, busy, grant_id, pkt_count
  );

endinterface

// File: rtl/switch_ingress_arb_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, modulo NUM_REQ.
// Returns a one-hot grant, its index and an any-grant flag; all zero when en is low.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (en && !any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/switch_ingress_arb.sv
// Round-robin ingress arbiter that serializes one PKT_W packet at a time MSB-first, then idles GAP_CYC cycles.
// SWITCH_ARB_PRIO_EN gives requester 0 strict priority over a round-robin among the rest.
module switch_ingress_arb
  import switch_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  switch_ingress_arb_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(PKT_W);
  localparam int GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [15:0]        pkt_count_q, pkt_count_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               arb_en;
  logic [NUM_REQ-1:0] rr_gnt, win_gnt;
  logic [IDW-1:0]     rr_idx, win_idx;
  logic               rr_any, win_any, ptr_upd;
  logic [PKT_W-1:0]   win_data;

  assign arb_en = bus.en && (state_q == IDLE);

`ifdef SWITCH_ARB_PRIO_EN
  logic prio0;
  assign prio0 = arb_en && bus.req_valid[0];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid & ~NUM_REQ'(1)),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Requester 0 bypasses the rotation and leaves ptr untouched.
  assign win_gnt = prio0 ? NUM_REQ'(1) : rr_gnt;
  assign win_idx = prio0 ? '0 : rr_idx;
  assign win_any = prio0 || rr_any;
  assign ptr_upd = rr_any && !prio0;
`else
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign win_gnt = rr_gnt;
  assign win_idx = rr_idx;
  assign win_any = rr_any;
  assign ptr_upd = rr_any;
`endif

  assign win_data = bus.req_data[win_idx*PKT_W +: PKT_W];

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    pkt_count_d = pkt_count_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d    = SHIFT;
          shreg_d    = win_data;
          bit_cnt_d  = '0;
          grant_id_d = win_idx;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          if (ptr_upd)
            ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == CW'(PKT_W - 1)) begin
          state_d     = GAP;
          bit_cnt_d   = '0;
          gap_cnt_d   = '0;
          valid_d     = 1'b0;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(GAP_CYC - 1)) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ptr_q       <= '0;
      grant_id_q  <= '0;
      pkt_count_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      pkt_count_q <= pkt_count_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = win_gnt;
  assign bus.data_out  = valid_q & shreg_q[PKT_W-1];
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_switch_ingress_arb.sv
// Directed bench for switch_ingress_arb with a grant/bit scoreboard fed by the stimulus.
module tb_switch_ingress_arb;
  import switch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  switch_ingress_arb_if #(.NUM_REQ(4)) bus ();

  switch_ingress_arb #(.NUM_REQ(4), .GAP_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit exp_bits[$];
  int exp_gnt[$];
  bit gap_chk  = 1'b0;
  bit seen_high = 1'b0;
  int low_run  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pkt_of(input int i);
    logic [31:0] lo;
    lo = 32'h9E37_79B9 * 32'(i + 1);
    return {16'hC0DE, 16'(i), lo};
  endfunction

  task automatic push_pkt(input logic [63:0] p);
    for (int i = 63; i >= 0; i--) exp_bits.push_back(p[i]);
  endtask

  task automatic wait_grant(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (bus.req_ready == 4'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_grant_seen"}, 64'(bus.req_ready != 4'b0), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (bus.busy !== 1'b0 && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_idle_seen"}, 64'(bus.busy), 64'd0);
  endtask

  // Scoreboard: every grant strobe and every valid serial bit is checked against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.req_ready !== 4'b0) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", 64'(bus.req_ready), 64'd0);
        else begin
          int g;
          logic [3:0] oh;
          g  = exp_gnt.pop_front();
          oh = 4'b0001 << g;
          chk("grant_onehot", 64'(bus.req_ready), 64'(oh));
        end
      end
      if (bus.valid_out === 1'b1) begin
        if (exp_bits.size() == 0) chk("unexpected_bit", 64'(bus.valid_out), 64'd0);
        else begin
          bit b;
          b = exp_bits.pop_front();
          chk("serial_bit", 64'(bus.data_out), 64'(b));
        end
        if (gap_chk && seen_high && low_run > 0) chk("gap_len", 64'(low_run), 64'd3);
        seen_high = 1'b1;
        low_run   = 0;
      end else begin
        low_run++;
      end
    end
  end

  initial begin
    logic [63:0] p;
    int          seq[4];
    int          cnt;

    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_data_out",  64'(bus.data_out),  64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_grant_id",  64'(bus.grant_id),  64'd0);
    chk("rst_pkt_count", 64'(bus.pkt_count), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single packet from requester 0.
    p = 64'hA5A5_0000_FFFF_0001;
    bus.req_data[63:0] = p;
    exp_gnt.push_back(0);
    push_pkt(p);
    bus.en        = 1'b1;
    bus.req_valid = 4'b0001;
    wait_grant("single");
    bus.req_valid = 4'b0000;
    chk("single_first_valid", 64'(bus.valid_out), 64'd1);
    chk("single_first_bit",   64'(bus.data_out),  64'(p[63]));
    chk("single_busy",        64'(bus.busy),      64'd1);
    repeat (64) @(posedge clk);
    #1;
    chk("single_gap1_valid", 64'(bus.valid_out), 64'd0);
    chk("single_gap1_busy",  64'(bus.busy),      64'd1);
    chk("single_pkt_count",  64'(bus.pkt_count), 64'd1);
    @(posedge clk);
    #1;
    chk("single_gap2_valid", 64'(bus.valid_out), 64'd0);
    chk("single_gap2_busy",  64'(bus.busy),      64'd1);
    @(posedge clk);
    #1;
    chk("single_idle_busy",  64'(bus.busy),      64'd0);
    chk("single_bits_left",  64'(exp_bits.size()), 64'd0);

    // Reset so the rotation starts from 0, then all four request for 8 packets.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = pkt_of(i);
    for (int i = 0; i < 8; i++) begin
      exp_gnt.push_back(i % 4);
      push_pkt(pkt_of(i % 4));
    end
    gap_chk       = 1'b1;
    seen_high     = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_grant("rr");
      chk("rr_grant_id", 64'(bus.grant_id), 64'(i % 4));
      chk("rr_ready_in_shift", 64'(bus.req_ready), 64'd0);
      if (i == 7) bus.req_valid = 4'b0000;
    end
    wait_idle("rr");
    gap_chk = 1'b0;
    chk("rr_pkt_count", 64'(bus.pkt_count), 64'd8);
    chk("rr_bits_left", 64'(exp_bits.size()), 64'd0);
    chk("rr_gnts_left", 64'(exp_gnt.size()), 64'd0);

    // en low blocks grants.
    bus.en        = 1'b0;
    bus.req_valid = 4'b1111;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) cnt++;
    end
    chk("en0_no_ready", 64'(cnt), 64'd0);

    // en dropped during SHIFT: packet finishes, nothing further is granted.
    @(posedge clk);
    #1;
    exp_gnt.push_back(0);
    push_pkt(pkt_of(0));
    bus.en = 1'b1;
    wait_grant("endrop");
    bus.en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("endrop_pkt_count", 64'(bus.pkt_count), 64'd9);
    chk("endrop_busy",      64'(bus.busy),      64'd0);
    chk("endrop_bits_left", 64'(exp_bits.size()), 64'd0);
    bus.req_valid = 4'b0000;

    // Reset in the middle of a packet.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_pre_count", 64'(bus.pkt_count), 64'd0);
    p = 64'h0123_4567_89AB_CDEF;
    bus.req_data[63:0] = p;
    exp_gnt.push_back(0);
    push_pkt(p);
    bus.en        = 1'b1;
    bus.req_valid = 4'b0001;
    wait_grant("midrst");
    bus.req_valid = 4'b0000;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_bit30_valid", 64'(bus.valid_out), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_bits.delete();
    chk("midrst_valid", 64'(bus.valid_out), 64'd0);
    chk("midrst_busy",  64'(bus.busy),      64'd0);
    chk("midrst_data",  64'(bus.data_out),  64'd0);
    rst = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    chk("midrst_pkt_count", 64'(bus.pkt_count), 64'd0);

    // Requesters 0 and 2 held, then 0 drops.
`ifdef SWITCH_ARB_PRIO_EN
    seq = '{0, 0, 0, 2};
`else
    seq = '{0, 2, 0, 2};
`endif
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back(seq[i]);
      push_pkt(pkt_of(seq[i]));
    end
    bus.req_data[63:0]    = pkt_of(0);
    bus.req_data[191:128] = pkt_of(2);
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_grant("pair");
      chk("pair_grant_id", 64'(bus.grant_id), 64'(seq[i]));
      if (i == 2) bus.req_valid = 4'b0100;
      if (i == 3) bus.req_valid = 4'b0000;
    end
    wait_idle("pair");
    chk("pair_pkt_count", 64'(bus.pkt_count), 64'd4);
    chk("pair_bits_left", 64'(exp_bits.size()), 64'd0);
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
